// File: rtl/cond_unit.sv
// Conditional-execution unit: holds the architectural {N,Z,C,V} flags, evaluates
// the instruction condition field and gates the decoder's write/branch enables.
module cond_unit #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             InstrValid,
   input  logic [3:0]       Cond,
   input  logic [3:0]       ALUFlag,
   input  logic [1:0]       FlagW,
   input  logic             PCS,
   input  logic             RegW,
   input  logic             MemW,
   input  logic             NoWrite,
   output logic             PCSrc,
   output logic             RegWrite,
   output logic             MemWrite,
   output logic             CondEx,
   output logic [3:0]       Flags,
   output logic [CNT_W-1:0] SkipCount
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [3:0]       flags_r;
   logic [CNT_W-1:0] skip_cnt_r;
   logic             cond_ex_s;
   logic             commit_s;
   logic             skip_s;

   function automatic logic cond_eval(input logic [3:0] cond, input logic [3:0] flg);
      logic n, z, c, v;
      logic res;
      {n, z, c, v} = flg;
      case (cond)
         4'b0000: res = z;
         4'b0001: res = ~z;
         4'b0010: res = c;
         4'b0011: res = ~c;
         4'b0100: res = n;
         4'b0101: res = ~n;
         4'b0110: res = v;
         4'b0111: res = ~v;
         4'b1000: res = c & ~z;
         4'b1001: res = ~c | z;
         4'b1010: res = (n == v);
         4'b1011: res = (n != v);
         4'b1100: res = ~z & (n == v);
         4'b1101: res = z | (n != v);
         4'b1110: res = 1'b1;
         default: res = 1'b0;
      endcase
      return res;
   endfunction

   // Condition decode and enable gating, always against the committed flags
   always_comb begin
      cond_ex_s = cond_eval(Cond, flags_r);
      commit_s  = InstrValid & cond_ex_s;
      skip_s    = InstrValid & ~cond_ex_s;
      PCSrc     = PCS & commit_s;
      RegWrite  = RegW & ~NoWrite & commit_s;
      MemWrite  = MemW & commit_s;
      CondEx    = cond_ex_s;
      Flags     = flags_r;
      SkipCount = skip_cnt_r;
   end

   // Architectural flag register; N,Z and C,V groups are written independently
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flags_r <= 4'b0000;
      end else if (commit_s) begin
         if (FlagW[1]) begin
            flags_r[3:2] <= ALUFlag[3:2];
         end
         if (FlagW[0]) begin
            flags_r[1:0] <= ALUFlag[1:0];
         end
      end
   end

   // Saturating count of valid instructions whose condition failed
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         skip_cnt_r <= {CNT_W{1'b0}};
      end else if (skip_s && (skip_cnt_r != CNT_MAX)) begin
         skip_cnt_r <= skip_cnt_r + CNT_ONE;
      end
   end

endmodule
